tcp_hdr_streamer: RTL and testbench

Scans the connection-record RAM and emits one complete Ethernet/IPv4/TCP header (54 bytes, padded to 14 × 32-bit words) for every record whose valid bit is set, as a valid/ready word stream toward the TX MAC path. It is the parametrised successor of the single-record packet builder: the connection count and window are configurable, records are scanned in order, and fixed header fields are filled in. It sits between the TOE connection RAM (read port) and the transmit framer.

---
 rtl/toe_hdr_pkg.sv | 30 +++
 rtl/ip_csum16.sv | 23 ++
 rtl/tcp_hdr_streamer.sv | 139 +++++++++++++
 tb/tb_tcp_hdr_streamer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toe_hdr_pkg.sv
// Shared constants and FSM state type for the TCP header streamer.
// Holds the record word offsets, fixed protocol values and the header length in words.
package toe_hdr_pkg;

    localparam int unsigned W_FLAGS      = 0;
    localparam int unsigned W_SEQ        = 1;
    localparam int unsigned W_ACK        = 2;
    localparam int unsigned W_IP_SRC     = 3;
    localparam int unsigned W_IP_DST     = 4;
    localparam int unsigned W_MAC_SRC_HI = 5;
    localparam int unsigned W_MAC_MIX    = 6;
    localparam int unsigned W_MAC_DST_LO = 7;
    localparam int unsigned W_PORTS      = 8;
    localparam int unsigned REC_WORDS    = 9;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_TCP   = 8'd6;
    localparam int unsigned HDR_WORDS      = 14;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StFetch,
        StBuild,
        StEmit,
        StNext,
        StDone
    } state_e;

endpackage

// File: rtl/ip_csum16.sv
// Combinational IPv4 header checksum over ten 16-bit halfwords.
// Output is the ones-complement of the end-around-carry sum.
module ip_csum16 (
    input  logic [9:0][15:0] i_hw,
    output logic [15:0]      o_csum
);

    logic [19:0] w_sum;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 10; i++) begin
            w_sum = w_sum + {4'b0000, i_hw[i]};
        end
        // Two folds suffice: ten halfwords carry at most 4 bits out.
        w_fold1 = {1'b0, w_sum[15:0]} + {13'b0, w_sum[19:16]};
        w_fold2 = w_fold1[15:0] + {15'b0, w_fold1[16]};
        o_csum  = ~w_fold2;
    end

endmodule

// File: rtl/tcp_hdr_streamer.sv
// Scans connection records and streams a 14-word Ethernet/IPv4/TCP header per valid record.
// Define TCP_HDR_STREAMER_IP_CSUM_EN to fill in the IPv4 header checksum.
module tcp_hdr_streamer
    import toe_hdr_pkg::*;
#(
    parameter int unsigned NUM_CONN   = 8,
    parameter int unsigned REC_STRIDE = 16,
    parameter int unsigned RAM_AW     = 9,
    parameter logic [15:0] TCP_WINDOW = 16'hFFFF,
    parameter logic [7:0]  IP_TTL     = 8'd64,
    parameter int unsigned CID_W      = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic [RAM_AW-1:0] o_ram_addr,
    input  logic [31:0]       i_ram_rdata,
    output logic [31:0]       o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_last,
    output logic [CID_W-1:0]  o_out_conn_id,
    output logic              o_busy,
    output logic              o_scan_done
);

    localparam int unsigned STRIDE_LG = $clog2(REC_STRIDE);

    state_e                        r_state, w_state_nxt;
    logic [CID_W-1:0]              r_idx;
    logic [3:0]                    r_cnt;
    logic [3:0]                    r_widx;
    logic [31:0]                   r_rec [REC_WORDS];
    logic [HDR_WORDS-1:0][31:0]    r_hdr;
    logic [HDR_WORDS-1:0][31:0]    w_hdr;
    logic [RAM_AW-1:0]             w_base;
    logic                          w_last_rec;
    logic [47:0]                   w_mac_src, w_mac_dst;
    logic [15:0]                   w_ip_csum;
    logic                          w_unused_flags;

    assign w_base         = RAM_AW'(r_idx) << STRIDE_LG;
    assign w_last_rec     = (r_idx == CID_W'(NUM_CONN - 1));
    assign w_unused_flags = ^r_rec[W_FLAGS][31:6];

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (i_start) w_state_nxt = StCheck;
            StCheck: w_state_nxt = StFetch;
            // First FETCH cycle sees word 0; an invalid record bails out here.
            StFetch: begin
                if (r_cnt == 4'd0 && !i_ram_rdata[31]) w_state_nxt = StNext;
                else if (r_cnt == 4'(W_PORTS))         w_state_nxt = StBuild;
            end
            StBuild: w_state_nxt = StEmit;
            StEmit:  if (i_out_ready && r_widx == 4'(HDR_WORDS - 1)) w_state_nxt = StNext;
            StNext:  w_state_nxt = w_last_rec ? StDone : StCheck;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        o_out_valid   = (r_state == StEmit);
        o_out_data    = o_out_valid ? r_hdr[r_widx] : 32'h0;
        o_out_last    = o_out_valid && (r_widx == 4'(HDR_WORDS - 1));
        o_out_conn_id = r_idx;
        o_busy        = (r_state != StIdle) && (r_state != StDone);
        o_scan_done   = (r_state == StDone);
        case (r_state)
            StCheck: o_ram_addr = w_base;
            StFetch: o_ram_addr = w_base + RAM_AW'(r_cnt) + RAM_AW'(1);
            default: o_ram_addr = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx  <= '0;
            r_cnt  <= '0;
            r_widx <= '0;
        end else begin
            case (r_state)
                StCheck: r_cnt <= '0;
                StFetch: r_cnt <= r_cnt + 4'd1;
                StBuild: r_widx <= '0;
                StEmit:  if (i_out_ready) r_widx <= r_widx + 4'd1;
                StNext:  if (!w_last_rec) r_idx <= r_idx + CID_W'(1);
                StDone:  r_idx <= '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_state == StFetch) r_rec[r_cnt] <= i_ram_rdata;
        if (r_state == StBuild) r_hdr <= w_hdr;
    end

`ifdef TCP_HDR_STREAMER_IP_CSUM_EN
    logic [9:0][15:0] w_ip_hw;
    assign w_ip_hw = {16'h4500, 16'd40, 16'h0000, 16'h4000, {IP_TTL, IP_PROTO_TCP}, 16'h0000,
                      r_rec[W_IP_SRC][31:16], r_rec[W_IP_SRC][15:0],
                      r_rec[W_IP_DST][31:16], r_rec[W_IP_DST][15:0]};
    ip_csum16 u_ip_csum16 (
        .i_hw   (w_ip_hw),
        .o_csum (w_ip_csum)
    );
`else
    assign w_ip_csum = 16'h0000;
`endif

    assign w_mac_src = {r_rec[W_MAC_SRC_HI], r_rec[W_MAC_MIX][31:16]};
    assign w_mac_dst = {r_rec[W_MAC_MIX][15:0], r_rec[W_MAC_DST_LO]};

    always_comb begin
        w_hdr[0]  = w_mac_dst[47:16];
        w_hdr[1]  = {w_mac_dst[15:0], w_mac_src[47:32]};
        w_hdr[2]  = w_mac_src[31:0];
        w_hdr[3]  = {ETHERTYPE_IPV4, 8'h45, 8'h00};
        w_hdr[4]  = {16'd40, 16'h0000};
        w_hdr[5]  = {16'h4000, IP_TTL, IP_PROTO_TCP};
        w_hdr[6]  = {w_ip_csum, r_rec[W_IP_SRC][31:16]};
        w_hdr[7]  = {r_rec[W_IP_SRC][15:0], r_rec[W_IP_DST][31:16]};
        w_hdr[8]  = {r_rec[W_IP_DST][15:0], r_rec[W_PORTS][31:16]};
        w_hdr[9]  = {r_rec[W_PORTS][15:0], r_rec[W_SEQ][31:16]};
        w_hdr[10] = {r_rec[W_SEQ][15:0], r_rec[W_ACK][31:16]};
        w_hdr[11] = {r_rec[W_ACK][15:0], 8'h50, 2'b00, r_rec[W_FLAGS][5:0]};
        w_hdr[12] = {TCP_WINDOW, 16'h0000};
        w_hdr[13] = 32'h0000_0000;
    end

endmodule

// File: tb/tb_tcp_hdr_streamer.sv
// Self-checking bench for tcp_hdr_streamer: byte-level header model, scoreboard and stall checks.
// Honours TCP_HDR_STREAMER_IP_CSUM_EN for the expected IPv4 checksum.
module tb_tcp_hdr_streamer;

    localparam int unsigned NC     = 4;
    localparam int unsigned STRIDE = 16;
    localparam int unsigned AW     = 9;
    localparam int unsigned CW     = 2;

    logic          clk = 1'b0;
    logic          rst, start, ready;
    logic [AW-1:0] ram_addr;
    logic [31:0]   rdata, data;
    logic          valid, last, busy, done;
    logic [CW-1:0] cid;
    logic [31:0]   ram [2**AW];
    logic [34:0]   exp_q [$];
    logic [31:0]   cap_q [$];
    int            checks = 0;
    int            errors = 0;
    bit            rand_ready = 1'b0;

    tcp_hdr_streamer #(
        .NUM_CONN   (NC),
        .REC_STRIDE (STRIDE),
        .RAM_AW     (AW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .o_ram_addr    (ram_addr),
        .i_ram_rdata   (rdata),
        .o_out_data    (data),
        .o_out_valid   (valid),
        .i_out_ready   (ready),
        .o_out_last    (last),
        .o_out_conn_id (cid),
        .o_busy        (busy),
        .o_scan_done   (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rdata <= ram[ram_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_rec(input int i, input bit v, input logic [5:0] fl, input logic [31:0] seq,
                           input logic [31:0] ack, input logic [31:0] src, input logic [31:0] dst,
                           input logic [47:0] ms, input logic [47:0] md, input logic [31:0] ports);
        int b;
        b = i * STRIDE;
        ram[b+0] = {v, 25'b0, fl};
        ram[b+1] = seq;
        ram[b+2] = ack;
        ram[b+3] = src;
        ram[b+4] = dst;
        ram[b+5] = ms[47:16];
        ram[b+6] = {ms[15:0], md[47:32]};
        ram[b+7] = md[31:0];
        ram[b+8] = ports;
    endtask

    task automatic rand_rec(input int i, input bit v);
        set_rec(i, v, 6'($urandom), $urandom, $urandom, $urandom, $urandom,
                {16'($urandom), $urandom}, {16'($urandom), $urandom}, $urandom);
    endtask

    // Expected header from the record, built as a 56-byte wire image.
    function automatic void push_hdr(input int i);
        logic [31:0] r [9];
        logic [7:0]  b [56];
        logic [47:0] ms, md;
        logic [15:0] cs;
        int          s;
        for (int k = 0; k < 9; k++) r[k] = ram[i*STRIDE + k];
        ms = {r[5], r[6][31:16]};
        md = {r[6][15:0], r[7]};
        for (int k = 0; k < 56; k++) b[k] = 8'h00;
        for (int k = 0; k < 6; k++) begin
            b[k]   = md[47-8*k -: 8];
            b[6+k] = ms[47-8*k -: 8];
        end
        b[12] = 8'h08; b[14] = 8'h45; b[17] = 8'd40; b[20] = 8'h40;
        b[22] = 8'd64; b[23] = 8'd6;
        for (int k = 0; k < 4; k++) begin
            b[26+k] = r[3][31-8*k -: 8];
            b[30+k] = r[4][31-8*k -: 8];
            b[34+k] = r[8][31-8*k -: 8];
            b[38+k] = r[1][31-8*k -: 8];
            b[42+k] = r[2][31-8*k -: 8];
        end
        b[46] = 8'h50; b[47] = {2'b00, r[0][5:0]}; b[48] = 8'hFF; b[49] = 8'hFF;
        cs = 16'h0000;
`ifdef TCP_HDR_STREAMER_IP_CSUM_EN
        s = 0;
        for (int k = 0; k < 10; k++) s += int'({b[14+2*k], b[15+2*k]});
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        cs = ~16'(s);
`else
        s = 0;
`endif
        b[24] = cs[15:8]; b[25] = cs[7:0];
        for (int j = 0; j < 14; j++)
            exp_q.push_back({CW'(i), j == 13, b[4*j], b[4*j+1], b[4*j+2], b[4*j+3]});
    endfunction

    function automatic void push_expected();
        for (int i = 0; i < NC; i++) if (ram[i*STRIDE][31]) push_hdr(i);
    endfunction

    function automatic bit sig(input int sel);
        return (sel == 0) ? valid : done;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_for(input int sel, input int budget, output int n);
        n = 1;
        while (!sig(sel) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!sig(sel)) begin
            checks++; errors++;
            $display("FAIL timeout_%0d: got no event expected one within %0d cycles", sel, budget);
        end
    endtask

    task automatic run_pass(input int budget, output int n);
        push_expected();
        pulse_start();
        wait_for(1, budget, n);
        check("pending_words", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_addr"}, ram_addr, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_last"}, last, 0);
        check({tag, "_cid"}, cid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Scoreboard and stall-stability checker.
    initial begin
        logic          pv, pr, pl;
        logic [31:0]   pd;
        logic [CW-1:0] pc;
        logic [34:0]   e;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    check("hold_valid", valid, 1);
                    check("hold_word", {cid, last, data}, {pc, pl, pd});
                end
                if (valid && ready) begin
                    cap_q.push_back(data);
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_word: got %0h expected no word", data);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", {cid, last, data}, e);
                    end
                end
                pv = valid; pr = ready; pd = data; pl = last; pc = cid;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; ready = 1'b1;
        for (int i = 0; i < 2**AW; i++) ram[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1 check_reset_outs("reset");
        rst = 1'b0;

        // Only record 2 valid, fixed fields.
        set_rec(2, 1'b1, 6'h12, 32'h11223344, 32'h55667788, 32'h0A000001, 32'h0A000002,
                48'h0011_2233_4455, 48'hAABB_CCDD_EEFF, 32'h1F900050);
        cap_q.delete();
        run_pass(200, n);
        check("one_rec_done_cycle", n, 36);
        check("one_rec_words", cap_q.size(), 14);
        if (cap_q.size() == 14) begin
            check("w0_mac_dst", cap_q[0], 32'hAABBCCDD);
            check("w3_ethertype", cap_q[3], 32'h08004500);
            check("w4_totlen", cap_q[4], 32'h00280000);
            check("w5_ttl_proto", cap_q[5], 32'h40004006);
`ifdef TCP_HDR_STREAMER_IP_CSUM_EN
            check("w6_csum", cap_q[6], 32'h26CE0A00);
`else
            check("w6_csum", cap_q[6], 32'h00000A00);
`endif
            check("w8_dst_sport", cap_q[8], 32'h00021F90);
            check("w11_ack_flags", cap_q[11], 32'h77885012);
            check("w12_window", cap_q[12], 32'hFFFF0000);
            check("w13_pad", cap_q[13], 32'h0);
        end

        // Record 0 valid: first-word latency.
        for (int i = 0; i < NC; i++) rand_rec(i, 1'b0);
        rand_rec(0, 1'b1);
        push_expected();
        pulse_start();
        wait_for(0, 100, n);
        check("first_valid_latency", n, 12);
        wait_for(1, 200, n);
        check("pending_rec0", exp_q.size(), 0);
        @(posedge clk); #1;

        // All invalid, with a redundant start mid-pass and one on scan_done.
        for (int i = 0; i < NC; i++) rand_rec(i, 1'b0);
        pulse_start();
        n = 1;
        repeat (3) begin @(posedge clk); #1; n++; end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0; n++;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        check("invalid_done_cycle", n, 1 + 3 * NC);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("start_on_done_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1 check("start_on_done_idle", {busy, done}, 0);

        // Random records with random back-pressure.
        rand_ready = 1'b1;
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < NC; i++) rand_rec(i, $urandom_range(0, 1) == 1);
            run_pass(3000, n);
        end
        rand_ready = 1'b0;

        // Reset while word 5 is presented, then a clean pass.
        for (int i = 0; i < NC; i++) rand_rec(i, 1'b0);
        rand_rec(0, 1'b1);
        @(posedge clk); #1;
        cap_q.delete();
        push_expected();
        pulse_start();
        n = 1;
        while (cap_q.size() < 5 && n < 200) begin @(posedge clk); #1; n++; end
        check("abort_at_word5", {valid, 32'(cap_q.size())}, {1'b1, 32'd5});
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outs("midrst");
        rst = 1'b0;
        exp_q.delete();
        repeat (3) begin
            @(posedge clk); #1 check("no_done_after_abort", done, 0);
        end
        cap_q.delete();
        run_pass(200, n);
        check("post_rst_words", cap_q.size(), 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
